// File: rtl/riscv_core_fetch_buffer.sv
// riscv_core_fetch_buffer
// Fetch stage for the 5-stage core. It issues sequential instruction-memory
// requests and queues the in-order responses, tagged with their PCs, in a
// DEPTH-entry FIFO whose head feeds Decode. A redirect from X flushes the
// FIFO and discards every response that is still in flight.
module riscv_core_fetch_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0008_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_msg_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_msg_data,
  input  logic        pc_redirect_val,
  input  logic [31:0] pc_redirect_target,
  output logic        inst_val_Dhl,
  input  logic        inst_rdy_Dhl,
  output logic [31:0] inst_Dhl,
  output logic [31:0] pc_Dhl
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE      = PW'(1'b1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;

  // Requests need a free credit: buffered plus outstanding must stay below DEPTH.
  // The reset term keeps the request line quiet while reset is held.
  always_comb begin
    credit_ok        = (({1'b0, count_q} + {1'b0, outst_q}) < CREDIT_LIMIT);
    imemreq_val      = reset && !pc_redirect_val && credit_ok;
    imemreq_msg_addr = fetch_pc_q;
    inst_val_Dhl     = (count_q != '0);
    inst_Dhl         = inst_mem_q[head_q];
    pc_Dhl           = pc_mem_q[head_q];
  end

  // Next-state for PCs, occupancy/credit counters, drop counter and pointers
  always_comb begin
    req_fire   = imemreq_val && imemreq_rdy;
    push       = imemresp_val && (drop_q == '0) && !pc_redirect_val;
    pop        = inst_val_Dhl && inst_rdy_Dhl && !pc_redirect_val;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q;

    if (pc_redirect_val) begin
      // Flush: everything still in flight (minus a response landing now) is stale.
      fetch_pc_d = pc_redirect_target;
      resp_pc_d  = pc_redirect_target;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      if (imemresp_val) begin
        drop_d = outst_q - CNT_ONE;
      end else begin
        drop_d = outst_q;
      end
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + PTR_ONE;
      end else begin
        resp_pc_d = resp_pc_q;
        tail_d    = tail_q;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (imemresp_val && (drop_q != '0)) begin
        drop_d = drop_q - CNT_ONE;
      end else begin
        drop_d = drop_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Every response retires one outstanding request, dropped or not.
    case ({req_fire, imemresp_val})
      2'b10:   outst_d = outst_q + CNT_ONE;
      2'b01:   outst_d = outst_q - CNT_ONE;
      default: outst_d = outst_q;
    endcase
  end

  // Control state: PCs, counters and FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      resp_pc_q  <= RESET_VECTOR;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // FIFO storage: accepted responses are written at the tail with their PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[tail_q] <= imemresp_msg_data;
      pc_mem_q[tail_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_riscv_core_fetch_buffer.sv
// Directed bench for riscv_core_fetch_buffer with a fixed-latency in-order
// instruction memory model. Inputs change at posedge+1, outputs are sampled
// at posedge+3.
module tb_riscv_core_fetch_buffer;

  localparam logic [31:0] RV = 32'h0008_0000;

  logic        clk;
  logic        reset;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_msg_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_msg_data;
  logic        pc_redirect_val;
  logic [31:0] pc_redirect_target;
  logic        inst_val_Dhl;
  logic        inst_rdy_Dhl;
  logic [31:0] inst_Dhl;
  logic [31:0] pc_Dhl;

  riscv_core_fetch_buffer #(.DEPTH(4), .RESET_VECTOR(RV)) dut (
    .clk                (clk),
    .reset              (reset),
    .imemreq_val        (imemreq_val),
    .imemreq_rdy        (imemreq_rdy),
    .imemreq_msg_addr   (imemreq_msg_addr),
    .imemresp_val       (imemresp_val),
    .imemresp_msg_data  (imemresp_msg_data),
    .pc_redirect_val    (pc_redirect_val),
    .pc_redirect_target (pc_redirect_target),
    .inst_val_Dhl       (inst_val_Dhl),
    .inst_rdy_Dhl       (inst_rdy_Dhl),
    .inst_Dhl           (inst_Dhl),
    .pc_Dhl             (pc_Dhl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc;
  int          lat;
  logic        req_rdy, dec_rdy, redir;
  logic [31:0] redir_tgt;
  logic        o_req_val, o_ival, o_fire, o_pop, o_resp;
  logic [31:0] o_req_addr, o_inst, o_pc;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive memory response and controls, sample, advance.
  task automatic run_cycle();
    logic resp_now;
    req_t r;
    resp_now = (pend.size() > 0) && (pend[0].due == cyc);
    imemresp_val       = resp_now;
    imemresp_msg_data  = resp_now ? mem_word(pend[0].addr) : 32'h0;
    imemreq_rdy        = req_rdy;
    inst_rdy_Dhl       = dec_rdy;
    pc_redirect_val    = redir;
    pc_redirect_target = redir_tgt;
    #2;
    o_req_val  = imemreq_val;
    o_req_addr = imemreq_msg_addr;
    o_ival     = inst_val_Dhl;
    o_inst     = inst_Dhl;
    o_pc       = pc_Dhl;
    o_fire     = imemreq_val && imemreq_rdy;
    o_pop      = inst_val_Dhl && inst_rdy_Dhl && !redir;
    o_resp     = resp_now;
    if (resp_now) void'(pend.pop_front());
    if (o_fire) begin
      r.addr = imemreq_msg_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imemresp_val = 1'b0; imemresp_msg_data = 32'h0; imemreq_rdy = 1'b0;
    inst_rdy_Dhl = 1'b0; pc_redirect_val = 1'b0; pc_redirect_target = 32'h0;
    req_rdy = 1'b1; dec_rdy = 1'b1; redir = 1'b0; redir_tgt = 32'h0;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imemresp_val = 1'b0; imemresp_msg_data = 32'h0; imemreq_rdy = 1'b1;
    inst_rdy_Dhl = 1'b1; pc_redirect_val = 1'b0; pc_redirect_target = 32'h0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (imemreq_val !== 1'b0) begin n_fail++; $display("FAIL reset_req_val got=%b exp=0", imemreq_val); end
    n_checks++; if (inst_val_Dhl !== 1'b0) begin n_fail++; $display("FAIL reset_inst_val got=%b exp=0", inst_val_Dhl); end
    n_checks++; if (inst_Dhl !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", inst_Dhl); end
    n_checks++; if (pc_Dhl !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_Dhl); end
    @(posedge clk);
    #1;
    n_checks++; if (imemreq_val !== 1'b0) begin n_fail++; $display("FAIL reset_req_val_hold got=%b exp=0", imemreq_val); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr, exp_pc;
    do_reset();
    lat = 1;
    exp_addr = RV;
    exp_pc = RV;
    for (int i = 0; i < 16; i++) begin
      run_cycle();
      n_checks++; if (o_req_val !== 1'b1) begin n_fail++; $display("FAIL seq_req_val cyc=%0d got=%b exp=1", i, o_req_val); end
      n_checks++; if (o_req_addr !== exp_addr) begin n_fail++; $display("FAIL seq_addr cyc=%0d got=%h exp=%h", i, o_req_addr, exp_addr); end
      exp_addr = exp_addr + 32'd4;
      if (i < 2) begin
        n_checks++; if (o_ival !== 1'b0) begin n_fail++; $display("FAIL seq_early_val cyc=%0d got=%b exp=0", i, o_ival); end
      end else begin
        n_checks++; if (o_ival !== 1'b1) begin n_fail++; $display("FAIL seq_val cyc=%0d got=%b exp=1", i, o_ival); end
        n_checks++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc cyc=%0d got=%h exp=%h", i, o_pc, exp_pc); end
        n_checks++; if (o_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL seq_inst cyc=%0d got=%h exp=%h", i, o_inst, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_addr, exp_pc;
    int fires, pops;
    do_reset();
    lat = 1;
    dec_rdy = 1'b0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (o_fire) fires++;
      if (i >= 2) begin
        n_checks++; if (o_ival !== 1'b1) begin n_fail++; $display("FAIL stall_val cyc=%0d got=%b exp=1", i, o_ival); end
        n_checks++; if (o_pc !== RV) begin n_fail++; $display("FAIL stall_head_pc cyc=%0d got=%h exp=%h", i, o_pc, RV); end
        n_checks++; if (o_inst !== mem_word(RV)) begin n_fail++; $display("FAIL stall_head_inst cyc=%0d got=%h exp=%h", i, o_inst, mem_word(RV)); end
      end
    end
    n_checks++; if (fires != 4) begin n_fail++; $display("FAIL stall_fires got=%0d exp=4", fires); end
    n_checks++; if (o_req_val !== 1'b0) begin n_fail++; $display("FAIL stall_req_blocked got=%b exp=0", o_req_val); end
    dec_rdy = 1'b1;
    exp_pc = RV;
    exp_addr = RV + 32'd16;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle();
      if (i == 0) begin
        n_checks++; if (o_req_val !== 1'b0) begin n_fail++; $display("FAIL release_req_first got=%b exp=0", o_req_val); end
      end
      if (i == 1) begin
        n_checks++; if (o_req_val !== 1'b1) begin n_fail++; $display("FAIL release_req_resume got=%b exp=1", o_req_val); end
      end
      if (o_fire) begin
        n_checks++; if (o_req_addr !== exp_addr) begin n_fail++; $display("FAIL release_addr cyc=%0d got=%h exp=%h", i, o_req_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (o_pop) begin
        n_checks++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL release_pc cyc=%0d got=%h exp=%h", i, o_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    n_checks++; if (pops != 20) begin n_fail++; $display("FAIL release_pops got=%0d exp=20", pops); end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] exp_pc;
    do_reset();
    lat = 3;
    exp_pc = 32'h0008_0200;
    for (int i = 0; i < 30; i++) begin
      redir = (i == 3) || (i == 5);
      redir_tgt = (i == 3) ? 32'h0008_0100 : 32'h0008_0200;
      run_cycle();
      if (redir) begin
        n_checks++; if (o_req_val !== 1'b0) begin n_fail++; $display("FAIL drop_req_in_redirect cyc=%0d got=%b exp=0", i, o_req_val); end
      end
      if (i == 4) begin
        n_checks++; if (o_req_addr !== 32'h0008_0100 || o_req_val !== 1'b1) begin n_fail++; $display("FAIL drop_first_req cyc=4 got=%h/%b exp=00080100/1", o_req_addr, o_req_val); end
      end
      if (i == 6) begin
        n_checks++; if (o_req_addr !== 32'h0008_0200 || o_req_val !== 1'b1) begin n_fail++; $display("FAIL drop_second_req cyc=6 got=%h/%b exp=00080200/1", o_req_addr, o_req_val); end
      end
      if (i < 10) begin
        n_checks++; if (o_ival !== 1'b0) begin n_fail++; $display("FAIL drop_stale_visible cyc=%0d pc=%h exp_val=0", i, o_pc); end
      end else if (i == 10) begin
        n_checks++; if (o_ival !== 1'b1) begin n_fail++; $display("FAIL drop_first_val cyc=10 got=%b exp=1", o_ival); end
      end
      if (o_ival) begin
        n_checks++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL drop_pc cyc=%0d got=%h exp=%h", i, o_pc, exp_pc); end
        n_checks++; if (o_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL drop_inst cyc=%0d got=%h exp=%h", i, o_inst, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    redir = 1'b0;
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp_pc;
    do_reset();
    lat = 2;
    exp_pc = 32'h0009_0000;
    for (int i = 0; i < 20; i++) begin
      redir = (i == 3);
      redir_tgt = 32'h0009_0000;
      run_cycle();
      if (i == 3) begin
        n_checks++; if (o_ival !== 1'b1 || o_pc !== RV) begin n_fail++; $display("FAIL rp_head_before cyc=3 got=%b/%h exp=1/%h", o_ival, o_pc, RV); end
        n_checks++; if (o_resp !== 1'b1) begin n_fail++; $display("FAIL rp_resp_same_cycle got=%b exp=1", o_resp); end
        n_checks++; if (o_req_val !== 1'b0) begin n_fail++; $display("FAIL rp_req_in_redirect got=%b exp=0", o_req_val); end
      end else if (i == 4) begin
        n_checks++; if (o_ival !== 1'b0) begin n_fail++; $display("FAIL rp_fifo_empty got=%b exp=0", o_ival); end
        n_checks++; if (o_req_val !== 1'b1 || o_req_addr !== 32'h0009_0000) begin n_fail++; $display("FAIL rp_new_req got=%b/%h exp=1/00090000", o_req_val, o_req_addr); end
      end else if (i > 4 && i < 7) begin
        n_checks++; if (o_ival !== 1'b0) begin n_fail++; $display("FAIL rp_stale_visible cyc=%0d pc=%h exp_val=0", i, o_pc); end
      end else if (i == 7) begin
        n_checks++; if (o_ival !== 1'b1) begin n_fail++; $display("FAIL rp_first_val cyc=7 got=%b exp=1", o_ival); end
      end
      if (i > 3 && o_ival) begin
        n_checks++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL rp_pc cyc=%0d got=%h exp=%h", i, o_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    redir = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [39:0] pat;
    logic [31:0] exp_pc;
    int occ, outm;
    do_reset();
    lat = 1;
    pat = 40'hA5_3C_F0_96_6E;
    occ = 0;
    outm = 0;
    exp_pc = RV;
    for (int i = 0; i < 40; i++) begin
      dec_rdy = (i < 6) ? 1'b0 : pat[i];
      run_cycle();
      n_checks++; if (o_ival !== (occ != 0)) begin n_fail++; $display("FAIL b2b_val cyc=%0d got=%b exp=%b", i, o_ival, (occ != 0)); end
      n_checks++; if (o_req_val !== ((occ + outm) < 4)) begin n_fail++; $display("FAIL b2b_credit cyc=%0d got=%b exp=%b", i, o_req_val, ((occ + outm) < 4)); end
      if (o_pop) begin
        n_checks++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL b2b_pc cyc=%0d got=%h exp=%h", i, o_pc, exp_pc); end
        n_checks++; if (o_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL b2b_inst cyc=%0d got=%h exp=%h", i, o_inst, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
      occ  = occ + int'(o_resp) - int'(o_pop);
      outm = outm + int'(o_fire) - int'(o_resp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_addr;
    do_reset();
    lat = 2;
    dec_rdy = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    n_checks++; if (inst_val_Dhl !== 1'b1 || pc_Dhl !== RV) begin n_fail++; $display("FAIL mid_pre_state got=%b/%h exp=1/%h", inst_val_Dhl, pc_Dhl, RV); end
    n_checks++; if (pend.size() != 2) begin n_fail++; $display("FAIL mid_outstanding got=%0d exp=2", pend.size()); end
    reset = 1'b0;
    #1;
    n_checks++; if (imemreq_val !== 1'b0) begin n_fail++; $display("FAIL mid_req_val got=%b exp=0", imemreq_val); end
    n_checks++; if (inst_val_Dhl !== 1'b0) begin n_fail++; $display("FAIL mid_inst_val got=%b exp=0", inst_val_Dhl); end
    n_checks++; if (inst_Dhl !== 32'h0 || pc_Dhl !== 32'h0) begin n_fail++; $display("FAIL mid_head_zero got=%h/%h exp=0/0", inst_Dhl, pc_Dhl); end
    do_reset();
    lat = 1;
    exp_addr = RV;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      n_checks++; if (o_req_val !== 1'b1 || o_req_addr !== exp_addr) begin n_fail++; $display("FAIL mid_restart_addr cyc=%0d got=%b/%h exp=1/%h", i, o_req_val, o_req_addr, exp_addr); end
      exp_addr = exp_addr + 32'd4;
      if (i == 2) begin
        n_checks++; if (o_ival !== 1'b1 || o_pc !== RV) begin n_fail++; $display("FAIL mid_restart_head got=%b/%h exp=1/%h", o_ival, o_pc, RV); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    lat = 1;
    req_rdy = 1'b1; dec_rdy = 1'b1; redir = 1'b0; redir_tgt = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drop();
    test_redirect_pop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
